// File: rtl/icache_bypass_pkg.sv
// Shared definitions for the uncached instruction fetch responder.
//   PRIV_MACHINE : reset/default privilege presented on the memory bus
//   LINE_W       : width of one fetch response (instruction pair)
//   TAG_W        : 8-byte block address width (pc[31:3])
//   state_e      : 3-bit sequencer encoding
package icache_bypass_pkg;

  localparam logic [1:0] PRIV_MACHINE = 2'b11;
  localparam int unsigned LINE_W      = 64;
  localparam int unsigned TAG_W       = 29;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_WAIT_LO  = 3'd2,
    ST_FETCH_HI = 3'd3,
    ST_WAIT_HI  = 3'd4
  } state_e;

endpackage

// File: rtl/icache_bypass_line_buf.sv
// Single-entry line buffer: one tag, one valid bit, one 64-bit line.
//   flush_i       : clear valid (wins over a fill in the same cycle)
//   fill_i        : load fill_tag_i / fill_data_i and set valid
//   lookup_tag_i  : tag compared against the stored entry
//   hit_o         : valid and tag match
//   data_o        : stored line
module icache_line_buf
  import icache_bypass_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_data_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [LINE_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_tag_i;
      data_d  = fill_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/icache_bypass.sv
// Uncached instruction fetch responder. Accepts 8-byte-aligned fetches and
// returns an instruction pair built from two 32-bit reads on a req/gnt bus.
// A single-entry line buffer answers repeat fetches of the same block in one
// cycle; flush/invalidate requests clear it.
//   req_*   : fetch request side (accept, pc, priv, flush, invalidate)
//   resp_*  : one-cycle response strobe with held instruction pair and error
//   mem_*   : 32-bit read bus, request held until grant, rvalid after grant
module icache_bypass
  import icache_bypass_pkg::*;
#(
  parameter bit BUFFER_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_rd_i,
  input  logic [31:0]       req_pc_i,
  input  logic [1:0]        req_priv_i,
  input  logic              req_flush_i,
  input  logic              req_invalidate_i,
  output logic              req_accept_o,
  output logic              resp_valid_o,
  output logic [LINE_W-1:0] resp_inst_o,
  output logic              resp_error_o,
  output logic              resp_page_fault_o,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  output logic [1:0]        mem_priv_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i
);

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  base_q, base_d;
  logic [1:0]        priv_q, priv_d;
  logic [31:0]       lo_q, lo_d;
  logic              flush_pend_q, flush_pend_d;
  logic              resp_valid_q, resp_valid_d;
  logic [LINE_W-1:0] resp_inst_q, resp_inst_d;
  logic              resp_error_q, resp_error_d;

  logic              flush;
  logic              buf_hit;
  logic [LINE_W-1:0] buf_data;
  logic              fill;
  logic              hi_beat;
  logic              unused_pc;

  assign flush     = req_flush_i | req_invalidate_i;
  assign unused_pc = ^req_pc_i[2:0];

  icache_line_buf u_line_buf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush),
    .fill_i       (fill),
    .fill_tag_i   (base_q),
    .fill_data_i  ({mem_rdata_i, lo_q}),
    .lookup_tag_i (req_pc_i[31:3]),
    .hit_o        (buf_hit),
    .data_o       (buf_data)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    priv_d       = priv_q;
    lo_d         = lo_q;
    flush_pend_d = flush_pend_q | (flush && (state_q != ST_IDLE));
    resp_valid_d = 1'b0;
    resp_inst_d  = resp_inst_q;
    resp_error_d = resp_error_q;
    fill         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_rd_i) begin
          base_d = req_pc_i[31:3];
          priv_d = req_priv_i;
          if (BUFFER_EN && buf_hit && !flush) begin
            resp_valid_d = 1'b1;
            resp_inst_d  = buf_data;
            resp_error_d = 1'b0;
          end else begin
            state_d = ST_FETCH_LO;
          end
        end
      end
      ST_FETCH_LO: if (mem_gnt_i) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (mem_rvalid_i) begin
          lo_d = mem_rdata_i;
          if (mem_err_i) begin
            resp_valid_d = 1'b1;
            resp_inst_d  = {32'h0, mem_rdata_i};
            resp_error_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_FETCH_HI;
          end
        end
      end
      ST_FETCH_HI: if (mem_gnt_i) state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (mem_rvalid_i) begin
          resp_valid_d = 1'b1;
          resp_inst_d  = {mem_rdata_i, lo_q};
          resp_error_d = mem_err_i;
          state_d      = ST_IDLE;
          // A flush landing in this same cycle has not reached flush_pend_q
          // yet, so it is checked directly to keep the line out of the buffer.
          fill = BUFFER_EN && !mem_err_i && !flush_pend_q && !flush;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) flush_pend_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      priv_q       <= PRIV_MACHINE;
      lo_q         <= '0;
      flush_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      priv_q       <= priv_d;
      lo_q         <= lo_d;
      flush_pend_q <= flush_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_inst_q  <= resp_inst_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign hi_beat           = (state_q == ST_FETCH_HI) || (state_q == ST_WAIT_HI);
  assign req_accept_o      = (state_q == ST_IDLE);
  assign resp_valid_o      = resp_valid_q;
  assign resp_inst_o       = resp_inst_q;
  assign resp_error_o      = resp_error_q;
  assign resp_page_fault_o = 1'b0;
  assign mem_req_o         = (state_q == ST_FETCH_LO) || (state_q == ST_FETCH_HI);
  assign mem_addr_o        = {base_q, hi_beat, 2'b00};
  assign mem_priv_o        = priv_q;

endmodule

// File: tb/tb_icache_bypass.sv
module tb_icache_bypass;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_rd_i = 1'b0;
  logic [31:0] req_pc_i = '0;
  logic [1:0]  req_priv_i = 2'b11;
  logic        req_flush_i = 1'b0;
  logic        req_invalidate_i = 1'b0;

  logic        req_accept_o, resp_valid_o, resp_error_o, resp_page_fault_o;
  logic [63:0] resp_inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_priv_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  logic        nb_accept, nb_resp_valid, nb_resp_error, nb_pf;
  logic [63:0] nb_resp_inst;
  logic        nb_mem_req;
  logic [31:0] nb_mem_addr;
  logic [1:0]  nb_mem_priv;
  logic        nb_gnt = 1'b0, nb_rvalid = 1'b0;
  logic [31:0] nb_rdata = '0;

  always #5 clk = ~clk;

  icache_bypass #(.BUFFER_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_rd_i(req_rd_i), .req_pc_i(req_pc_i), .req_priv_i(req_priv_i),
    .req_flush_i(req_flush_i), .req_invalidate_i(req_invalidate_i),
    .req_accept_o(req_accept_o), .resp_valid_o(resp_valid_o),
    .resp_inst_o(resp_inst_o), .resp_error_o(resp_error_o),
    .resp_page_fault_o(resp_page_fault_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_priv_o(mem_priv_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  icache_bypass #(.BUFFER_EN(1'b0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_rd_i(req_rd_i), .req_pc_i(req_pc_i), .req_priv_i(req_priv_i),
    .req_flush_i(req_flush_i), .req_invalidate_i(req_invalidate_i),
    .req_accept_o(nb_accept), .resp_valid_o(nb_resp_valid),
    .resp_inst_o(nb_resp_inst), .resp_error_o(nb_resp_error),
    .resp_page_fault_o(nb_pf),
    .mem_req_o(nb_mem_req), .mem_addr_o(nb_mem_addr), .mem_priv_o(nb_mem_priv),
    .mem_gnt_i(nb_gnt), .mem_rvalid_i(nb_rvalid),
    .mem_rdata_i(nb_rdata), .mem_err_i(1'b0)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0013;
      32'h8000_0004: return 32'h0010_0093;
      32'h8000_0008: return 32'h0000_0517;
      32'h8000_000C: return 32'hFFC5_0513;
      32'h0000_1000: return 32'hDEAD_BEEF;
      32'h0000_1004: return 32'hCAFE_F00D;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory responder for the buffered instance: grant after gnt_delay
  // waiting cycles, read data one cycle after grant.
  int          gnt_delay = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int          gnt_n = 0;
  logic [31:0] last_gnt_addr = '0, prev_gnt_addr = '0;
  int          wcnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  always @(negedge clk) begin
    mem_rvalid_i = pend;
    mem_rdata_i  = mem_read(pend_addr);
    mem_err_i    = pend && err_en && (pend_addr == err_addr);
    pend         = 1'b0;
    mem_gnt_i    = 1'b0;
    if (mem_req_o) begin
      if (wcnt >= gnt_delay) begin
        mem_gnt_i     = 1'b1;
        pend          = 1'b1;
        pend_addr     = mem_addr_o;
        prev_gnt_addr = last_gnt_addr;
        last_gnt_addr = mem_addr_o;
        gnt_n         = gnt_n + 1;
        wcnt          = 0;
      end else begin
        wcnt = wcnt + 1;
      end
    end
  end

  // Zero-wait responder for the unbuffered instance.
  logic        nb_pend = 1'b0;
  logic [31:0] nb_pend_addr = '0;
  always @(negedge clk) begin
    nb_rvalid    = nb_pend;
    nb_rdata     = mem_read(nb_pend_addr);
    nb_pend      = nb_mem_req;
    nb_pend_addr = nb_mem_addr;
    nb_gnt       = nb_mem_req;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic flush, input int flush_cyc,
                          output int lat, output int nreq,
                          output logic [63:0] inst, output logic err);
    int w;
    int base;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [1:0]  prev_priv;
    w = 0;
    @(negedge clk);
    while (!req_accept_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_accept_o) chk("accept_timeout", {63'h0, req_accept_o}, 64'h1);
    base        = gnt_n;
    req_rd_i    = 1'b1;
    req_pc_i    = pc;
    req_flush_i = flush;
    @(posedge clk); #1;
    req_rd_i    = 1'b0;
    req_flush_i = 1'b0;
    prev_req  = 1'b0;
    prev_addr = '0;
    prev_priv = '0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      req_invalidate_i = (k == flush_cyc);
      if (mem_req_o && prev_req) begin
        chk("addr_stable", {32'h0, mem_addr_o}, {32'h0, prev_addr});
        chk("priv_stable", {62'h0, mem_priv_o}, {62'h0, prev_priv});
      end
      prev_req  = mem_req_o;
      prev_addr = mem_addr_o;
      prev_priv = mem_priv_o;
      if (resp_valid_o) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    req_invalidate_i = 1'b0;
    nreq = gnt_n - base;
    inst = resp_inst_o;
    err  = resp_error_o;
  endtask

  task automatic nb_fetch(input logic [31:0] pc, output int lat, output logic [63:0] inst);
    int w;
    w = 0;
    @(negedge clk);
    while (!nb_accept && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!nb_accept) chk("nb_accept_timeout", {63'h0, nb_accept}, 64'h1);
    req_rd_i = 1'b1;
    req_pc_i = pc;
    @(posedge clk); #1;
    req_rd_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (nb_resp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    inst = nb_resp_inst;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic [63:0] inst;
    logic        err;
    int          lat;
    int          nreq;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          lat, nreq;
    logic [63:0] inst;
    logic        err;
    logic        saw_resp, saw_req;

    vecs[0] = '{32'h8000_0004, 1'b0, 64'h0010_0093_0000_0013, 1'b0, 5, 2};
    vecs[1] = '{32'h8000_0000, 1'b0, 64'h0010_0093_0000_0013, 1'b0, 1, 0};
    vecs[2] = '{32'h8000_0008, 1'b0, 64'hFFC5_0513_0000_0517, 1'b0, 5, 2};
    vecs[3] = '{32'h8000_000C, 1'b0, 64'hFFC5_0513_0000_0517, 1'b0, 1, 0};
    vecs[4] = '{32'h8000_0000, 1'b0, 64'h0010_0093_0000_0013, 1'b0, 5, 2};
    vecs[5] = '{32'h8000_0004, 1'b1, 64'h0010_0093_0000_0013, 1'b0, 5, 2};
    vecs[6] = '{32'h0000_1000, 1'b0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 5, 2};
    vecs[7] = '{32'h0000_1007, 1'b0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("rst_accept",     {63'h0, req_accept_o}, 64'h1);
    chk("rst_resp_valid", {63'h0, resp_valid_o}, 64'h0);
    chk("rst_mem_req",    {63'h0, mem_req_o},    64'h0);
    chk("rst_mem_priv",   {62'h0, mem_priv_o},   64'h3);
    chk("rst_page_fault", {63'h0, resp_page_fault_o}, 64'h0);

    for (int i = 0; i < 8; i++) begin
      do_fetch(vecs[i].pc, vecs[i].flush, 0, lat, nreq, inst, err);
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].inst);
      chk($sformatf("vec%0d_err", i),  {63'h0, err}, {63'h0, vecs[i].err});
      chk($sformatf("vec%0d_lat", i),  64'(lat),  64'(vecs[i].lat));
      chk($sformatf("vec%0d_nreq", i), 64'(nreq), 64'(vecs[i].nreq));
      if (vecs[i].nreq == 2) begin
        chk($sformatf("vec%0d_addr_lo", i), {32'h0, prev_gnt_addr}, {32'h0, vecs[i].pc[31:3], 3'b000});
        chk($sformatf("vec%0d_addr_hi", i), {32'h0, last_gnt_addr}, {32'h0, vecs[i].pc[31:3], 3'b100});
      end
    end

    // Error on the low beat: short response, no high request, not buffered.
    do_fetch(32'h8000_0000, 1'b0, 0, lat, nreq, inst, err);
    chk("err_pre_lat", 64'(lat), 64'd5);
    err_en   = 1'b1;
    err_addr = 32'h0000_1000;
    do_fetch(32'h0000_1000, 1'b0, 0, lat, nreq, inst, err);
    chk("err_flag", {63'h0, err}, 64'h1);
    chk("err_lat",  64'(lat),  64'd3);
    chk("err_nreq", 64'(nreq), 64'd1);
    chk("err_addr", {32'h0, last_gnt_addr}, 64'h0000_1000);
    err_en = 1'b0;
    do_fetch(32'h0000_1004, 1'b0, 0, lat, nreq, inst, err);
    chk("err_refetch_lat",  64'(lat), 64'd5);
    chk("err_refetch_err",  {63'h0, err}, 64'h0);
    chk("err_refetch_inst", inst, 64'hCAFE_F00D_DEAD_BEEF);

    // Invalidate during WAIT_HI: delivered, not buffered; a later fill works.
    do_fetch(32'h8000_0008, 1'b0, 4, lat, nreq, inst, err);
    chk("wflush_lat",  64'(lat), 64'd5);
    chk("wflush_inst", inst, 64'hFFC5_0513_0000_0517);
    do_fetch(32'h8000_000C, 1'b0, 0, lat, nreq, inst, err);
    chk("wflush_after_lat",  64'(lat),  64'd5);
    chk("wflush_after_nreq", 64'(nreq), 64'd2);
    do_fetch(32'h8000_0008, 1'b0, 0, lat, nreq, inst, err);
    chk("refill_hit_lat", 64'(lat), 64'd1);

    // Grant delayed by 3 cycles on each beat, non-machine privilege.
    gnt_delay  = 3;
    req_priv_i = 2'b01;
    do_fetch(32'h8000_0000, 1'b0, 0, lat, nreq, inst, err);
    chk("slow_lat",  64'(lat), 64'd11);
    chk("slow_inst", inst, 64'h0010_0093_0000_0013);
    chk("slow_priv", {62'h0, mem_priv_o}, 64'h1);
    gnt_delay  = 0;
    req_priv_i = 2'b11;

    // Reset pulse in WAIT_LO: the pending read data then lands in IDLE.
    @(negedge clk);
    req_rd_i = 1'b1;
    req_pc_i = 32'h8000_0008;
    @(posedge clk); #1;
    req_rd_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_waiting", {63'h0, req_accept_o}, 64'h0);
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    saw_resp = 1'b0;
    saw_req  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid_o) saw_resp = 1'b1;
      if (mem_req_o)    saw_req  = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_resp", {63'h0, saw_resp}, 64'h0);
    chk("rst_mid_no_req",  {63'h0, saw_req},  64'h0);
    chk("rst_mid_accept",  {63'h0, req_accept_o}, 64'h1);
    chk("rst_mid_priv",    {62'h0, mem_priv_o}, 64'h3);
    do_fetch(32'h8000_0000, 1'b0, 0, lat, nreq, inst, err);
    chk("rst_mid_buf_gone", 64'(lat), 64'd5);

    // Buffer disabled: repeat fetches always go to memory.
    nb_fetch(32'h8000_0000, lat, inst);
    chk("nb_first_lat",  64'(lat), 64'd5);
    chk("nb_first_inst", nb_resp_inst, 64'h0010_0093_0000_0013);
    nb_fetch(32'h8000_0000, lat, inst);
    chk("nb_repeat_lat",  64'(lat), 64'd5);
    chk("nb_repeat_inst", inst, 64'h0010_0093_0000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_bypass.md
# icache_bypass

Uncached instruction-memory responder that sits on the cache side of the fetch interface. It accepts 64-bit-aligned fetch reads and returns a 64-bit instruction pair by issuing two 32-bit reads on a simple request/grant memory bus. A single-entry line buffer serves repeat fetches of the same 8-byte block in one cycle; flush requests invalidate that buffer. Page faults are never raised because there is no MMU on this path.

## Interface
- BUFFER_EN, 1, enables the single-entry line buffer; 0 makes every fetch a miss
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_rd_i  in  1  fetch read request
- req_pc_i  in  32  fetch address; [2:0] ignored
- req_priv_i  in  2  privilege of the request; captured on accept
- req_flush_i  in  1  invalidate line buffer
- req_invalidate_i  in  1  treated identically to req_flush_i
- req_accept_o  out  1  request accepted this cycle if req_rd_i is high
- resp_valid_o  out  1  single-cycle response strobe
- resp_inst_o  out  64  {word @ +4, word @ +0}
- resp_error_o  out  1  bus error on the response
- resp_page_fault_o  out  1  constant 0
- mem_req_o  out  1  memory read request, held until mem_gnt_i
- mem_addr_o  out  32  word address
- mem_priv_o  out  2  captured req_priv_i
- mem_gnt_i  in  1  request granted
- mem_rvalid_i  in  1  read data valid, at least one cycle after grant
- mem_rdata_i  in  32  read data
- mem_err_i  in  1  read error, qualified by mem_rvalid_i

## Operation
- States:
  - IDLE: req_accept_o=1.
  - FETCH_LO: mem_req_o=1, mem_addr_o={base,3'b000}.
  - WAIT_LO
  - FETCH_HI: mem_req_o=1, mem_addr_o={base,3'b100}.
  - WAIT_HI
- Capturing a request: in IDLE, req_rd_i=1 captures base=req_pc_i[31:3] and priv.
  - Hit, when BUFFER_EN, buf_valid, tag==base and no flush in the same cycle: load resp regs from the buffer and stay in IDLE.
  - Otherwise go to FETCH_LO.
- FETCH_LO→WAIT_LO on mem_gnt_i.
- WAIT_LO on mem_rvalid_i:
  - Store the low word.
  - If mem_err_i: respond with error and go to IDLE, skipping the high beat.
  - Else go to FETCH_HI.
- FETCH_HI→WAIT_HI on mem_gnt_i.
- WAIT_HI on mem_rvalid_i:
  - Respond with {rdata, lo} and resp_error_o=mem_err_i; go to IDLE.
  - Fill the buffer (tag=base, valid=1) only if there was no error and no flush_pend.
- Flush: req_flush_i or req_invalidate_i in any state clears buf_valid.
  - If it arrives outside IDLE, set flush_pend, cleared on return to IDLE.
  - The in-flight response is still delivered, but not buffered.
- mem_rvalid_i in IDLE or FETCH_* is ignored, e.g. stale data after a reset.
- mem_req_o, mem_addr_o and mem_priv_o stay stable while waiting for grant.

## Timing
- Reset values:
  - state IDLE, buf_valid 0, flush_pend 0.
  - All outputs 0 except req_accept_o=1; mem_priv_o=2'b11.
- Hit: request accepted in cycle N; resp_valid_o in N+1.
- Miss with zero-wait memory (grant same cycle, rvalid next cycle):

| Cycle | Event |
|---|---|
| N+1 | mem_req_o lo |
| N+2 | rvalid lo |
| N+3 | mem_req_o hi |
| N+4 | rvalid hi |
| N+5 | resp_valid_o |

- req_accept_o is high again in the resp_valid_o cycle, so back-to-back fetches are allowed.
- resp_inst_o and resp_error_o hold their value until the next response.
- Reset asserted mid-transaction: immediately go to IDLE, drop mem_req_o, invalidate the buffer, and produce no response.

## Structure
- The shared package holds:
  - PRIV_MACHINE (2'b11)
  - the 3-bit state encoding
  - the line width constant (64)
- One optional sub-module, icache_line_buf: tag/valid/data register with a hit compare, and fill/flush ports.

## Test plan
- Reset release → req_accept_o=1, resp_valid_o=0, mem_req_o=0, mem_priv_o=2'b11.
- Miss at req_pc_i=0x8000_0004 with memory 0x80000000=0x00000013 and 0x80000004=0x00100093 → mem_addr_o 0x80000000 then 0x80000004; resp_inst_o=0x00100093_00000013, resp_error_o=0, response in N+5.
- Repeat fetch at 0x80000000 → resp_valid_o in N+1 with the same data and no mem_req_o; with BUFFER_EN=0 it misses instead.
- mem_err_i on the low beat → resp_error_o=1, no request to 0x80000004; the next fetch of the same block misses.
- req_flush_i during WAIT_HI → response still delivered; the following same-block fetch issues mem_req_o again. Flush coincident with an IDLE hit → treated as a miss.
- mem_gnt_i delayed 3 cycles → mem_req_o and mem_addr_o held stable. rst_ni pulsed in WAIT_LO → IDLE, no resp_valid_o, and a late mem_rvalid_i is ignored.
